digital_debounce_3v3: RTL and testbench

- Sequential input conditioner for asynchronous 3.3 V pad-side digital signals (buttons, GPIO inputs, external strobes).
- Synchronizes the raw input, rejects glitches shorter than a programmable number of clocks, and produces a clean level, edge pulses and a sticky pending flag.
- Its level output Q feeds the buffer/inverter cell stage directly downstream, which drives the core.

---
 rtl/digital_debounce_3v3.sv | 97 +++++++++
 tb/tb_digital_debounce_3v3.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/digital_debounce_3v3.sv
// Pad-input conditioner: synchronizer, glitch-rejecting debounce counter, edge pulses and sticky pending flag.
// Optional macro DIGITAL_DEBOUNCE_BYPASS_EN adds a bypass input that lets Q follow the synchronized input directly.
module digital_debounce_3v3 #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        INIT_VAL        = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic A,
    input  logic en,
    input  logic rise_en,
    input  logic fall_en,
    input  logic clr,
`ifdef DIGITAL_DEBOUNCE_BYPASS_EN
    input  logic bypass,
`endif
    output logic Q,
    output logic rise,
    output logic fall,
    output logic pend
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   pend_q, pend_d;
    logic                   a_sync;

    assign a_sync = sync_q[SYNC_STAGES-1];

    // Next-state: shift synchronizer, run the stability counter, derive edges and pending flag.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], A};
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        pend_d = pend_q;

`ifdef DIGITAL_DEBOUNCE_BYPASS_EN
        if (bypass) begin
            q_d   = a_sync;
            cnt_d = '0;
        end else
`endif
        begin
            if (!en || (a_sync == q_q)) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                q_d   = a_sync;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;

        // A new edge outranks a simultaneous clear.
        if ((rise_d && rise_en) || (fall_d && fall_en)) begin
            pend_d = 1'b1;
        end else if (clr) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{INIT_VAL}};
            cnt_q  <= '0;
            q_q    <= INIT_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
        end
    end

    assign Q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign pend = pend_q;

endmodule

// File: tb/tb_digital_debounce_3v3.sv
// Scoreboarded random/directed bench for digital_debounce_3v3 against a run-length reference model.
module tb_digital_debounce_3v3;

    localparam int unsigned SS = 2;
    localparam int unsigned DC = 16;
    localparam logic        IV = 1'b0;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic pend;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic A = 1'b0;
    logic en = 1'b1;
    logic rise_en = 1'b1;
    logic fall_en = 1'b1;
    logic clr = 1'b0;
    logic byp = 1'b0;
    logic Q, rise, fall, pend;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic        m_hist[$];
    int unsigned m_run;
    logic        m_q;
    logic        m_pend;

    digital_debounce_3v3 #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .INIT_VAL       (IV)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .A      (A),
        .en     (en),
        .rise_en(rise_en),
        .fall_en(fall_en),
        .clr    (clr),
`ifdef DIGITAL_DEBOUNCE_BYPASS_EN
        .bypass (byp),
`endif
        .Q      (Q),
        .rise   (rise),
        .fall   (fall),
        .pend   (pend)
    );

    always #5 clk = ~clk;

    // Reference: Q flips once the synchronized input has differed from Q for DC consecutive enabled cycles.
    task automatic model_step();
        logic as, nq, r, f;
        exp_t e;
        if (!resetn) begin
            m_hist = {};
            for (int i = 0; i < int'(SS); i++) m_hist.push_back(IV);
            m_run  = 0;
            m_q    = IV;
            m_pend = 1'b0;
            r = 1'b0;
            f = 1'b0;
        end else begin
            as = m_hist[SS-1];
            nq = m_q;
`ifdef DIGITAL_DEBOUNCE_BYPASS_EN
            if (byp) begin
                nq    = as;
                m_run = 0;
            end else
`endif
            if (en && (as != m_q)) begin
                m_run = m_run + 1;
                if (m_run >= DC) begin
                    nq    = as;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            r = nq && !m_q;
            f = !nq && m_q;
            if ((r && rise_en) || (f && fall_en)) m_pend = 1'b1;
            else if (clr) m_pend = 1'b0;
            m_q = nq;
            m_hist.push_front(A);
            void'(m_hist.pop_back());
        end
        e.q    = m_q;
        e.rise = r;
        e.fall = f;
        e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic a_i, input logic en_i, input logic re_i, input logic fe_i,
                       input logic clr_i, input logic rst_i, input logic byp_i);
        A       = a_i;
        en      = en_i;
        rise_en = re_i;
        fall_en = fe_i;
        clr     = clr_i;
        resetn  = rst_i;
        byp     = byp_i;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic hold(input logic a_i, input int n, input logic clr_i);
        for (int i = 0; i < n; i++) cyc(a_i, 1'b1, 1'b1, 1'b1, clr_i, 1'b1, 1'b0);
    endtask

    // Monitor: one expected vector per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if ({Q, rise, fall, pend} !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t {Q,rise,fall,pend} got=%b%b%b%b want=%b%b%b%b",
                         $time, Q, rise, fall, pend, e.q, e.rise, e.fall, e.pend);
            end
        end
    end

    initial begin
        int unsigned len;
        logic a_v, re_v, fe_v, by_v;

        for (int i = 0; i < int'(SS); i++) m_hist.push_back(IV);
        m_run = 0; m_q = IV; m_pend = 1'b0;

        // Reset with A high, then release and wait for the debounced rise.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 25, 1'b0);
        hold(1'b1, 2, 1'b1);
        // Glitch of DC-1 cycles is rejected; DC cycles passes.
        hold(1'b0, 25, 1'b0);
        hold(1'b1, DC - 1, 1'b0);
        hold(1'b0, 25, 1'b0);
        hold(1'b1, DC, 1'b0);
        hold(1'b0, 25, 1'b1);
        // Enable dropped mid-count.
        hold(1'b1, 12, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 25, 1'b0);
        // Falling edge coincident with a held clr, rise_en off.
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Reset mid-count.
        hold(1'b1, 9, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 25, 1'b0);
`ifdef DIGITAL_DEBOUNCE_BYPASS_EN
        for (int t = 0; t < 8; t++)
            for (int i = 0; i < 3; i++)
                cyc(1'(t % 2), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
`endif
        // Random segments.
        for (int s = 0; s < 70; s++) begin
            len  = $urandom_range(1, 35);
            a_v  = 1'($urandom_range(0, 1));
            re_v = 1'($urandom_range(0, 1));
            fe_v = 1'($urandom_range(0, 1));
            by_v = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < int'(len); i++)
                cyc(a_v, ($urandom_range(0, 19) != 0), re_v, fe_v,
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) != 0), by_v);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        if (n_vec < 12) begin
            n_err++;
            $display("FAIL vector_count got=%0d want>=12", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
